// File: rtl/demux_1to2_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: lane indices,
// per-lane buffer state encoding and default widths.
package demux_1to2_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux_1to2_stream_if.sv
// Stream bundle for the demux: one selectable input stream and two output lanes.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
// the producer holds valid and its payload stable until that edge, ready may change freely.
interface demux_1to2_stream_if
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/demux_1to2_stream_lane.sv
// One output lane: single-entry buffer with EMPTY/FULL state, delivered-beat
// counter and the lane's contribution to the shared input ready.
module demux_1to2_stream_lane
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             can_accept,
  output lane_state_t      state
);

  logic drain;

  assign out_valid  = (state == FULL);
  assign drain      = out_valid & out_ready;
  // A draining buffer can take a new beat in the same cycle, giving full rate.
  assign can_accept = (state == EMPTY) | drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      cnt      <= '0;
    end else begin
      if (load) out_data <= load_data;
      if (drain) cnt <= cnt + CNT_W'(1);
      unique case (state)
        EMPTY: if (load) state <= FULL;
        FULL:  if (drain && !load) state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer: steers each input beat to lane 0 or 1
// by in_sel; each lane buffers one beat so there is no input-to-output comb path.
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  demux_1to2_stream_if.slave      bus,
  output logic [CNT_W-1:0]        cnt0,
  output logic [CNT_W-1:0]        cnt1,
  output logic                    busy,
  output lane_state_t             state0,
  output lane_state_t             state1
);

  logic acc0, acc1;
  logic fire, load0, load1;

  // Ready looks only at the addressed lane, so a stalled lane never blocks the other.
  assign bus.in_ready = !rst && ((bus.in_sel == LANE1) ? acc1 : acc0);
  assign fire         = bus.in_valid & bus.in_ready;
  assign load0        = fire & (bus.in_sel == LANE0);
  assign load1        = fire & (bus.in_sel == LANE1);
  assign busy         = bus.out0_valid | bus.out1_valid;

  demux_1to2_stream_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane0 (
    .clk        (clk),
    .rst        (rst),
    .load       (load0),
    .load_data  (bus.in_data),
    .out_ready  (bus.out0_ready),
    .out_data   (bus.out0_data),
    .out_valid  (bus.out0_valid),
    .cnt        (cnt0),
    .can_accept (acc0),
    .state      (state0)
  );

  demux_1to2_stream_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane1 (
    .clk        (clk),
    .rst        (rst),
    .load       (load1),
    .load_data  (bus.in_data),
    .out_ready  (bus.out1_ready),
    .out_data   (bus.out1_data),
    .out_valid  (bus.out1_valid),
    .cnt        (cnt1),
    .can_accept (acc1),
    .state      (state1)
  );

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Bench for demux_1to2_stream: directed scenarios plus a randomized run, all
// checked against a queue-based model of the two one-beat lanes.
module tb_demux_1to2_stream;
  import demux_1to2_stream_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_1to2_stream_if #(.WIDTH(W)) bus ();
  logic [CW-1:0] cnt0, cnt1;
  logic          busy;
  lane_state_t   state0, state1;

  demux_1to2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .cnt0   (cnt0),
    .cnt1   (cnt1),
    .busy   (busy),
    .state0 (state0),
    .state1 (state1)
  );

  int checks   = 0;
  int failures = 0;

  // model: each lane holds at most one beat; counters count delivered beats
  logic [W-1:0]  exp_q0[$];
  logic [W-1:0]  exp_q1[$];
  logic [CW-1:0] m_cnt0 = '0;
  logic [CW-1:0] m_cnt1 = '0;
  logic          m_rdy;
  logic          d_v, d_sel, d_r0, d_r1;
  logic [W-1:0]  d_data;

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
  endtask

  // driver: apply inputs just after a falling edge and predict in_ready
  task automatic drive(input logic v, input logic sel, input logic [W-1:0] data,
                       input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.in_sel     = sel;
    bus.in_data    = data;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    d_v = v; d_sel = sel; d_data = data; d_r0 = r0; d_r1 = r1;
    #1;
    m_rdy = !rst && (sel ? (exp_q1.size() == 0 || r1) : (exp_q0.size() == 0 || r0));
  endtask

  // advance one clock and move the model across the rising edge
  task automatic tick();
    logic dr0, dr1;
    @(posedge clk);
    if (!rst) begin
      dr0 = (exp_q0.size() != 0) && d_r0;
      dr1 = (exp_q1.size() != 0) && d_r1;
      if (dr0) begin void'(exp_q0.pop_front()); m_cnt0 = m_cnt0 + 1'b1; end
      if (dr1) begin void'(exp_q1.pop_front()); m_cnt1 = m_cnt1 + 1'b1; end
      if (d_v && m_rdy) begin
        if (d_sel) exp_q1.push_back(d_data);
        else       exp_q0.push_back(d_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.out0_valid !== 1'b0) begin failures++; $display("FAIL rst_v0 got=%b exp=0", bus.out0_valid); end
    checks++; if (bus.out1_valid !== 1'b0) begin failures++; $display("FAIL rst_v1 got=%b exp=0", bus.out1_valid); end
    checks++; if (bus.out0_data !== 8'h00) begin failures++; $display("FAIL rst_d0 got=%h exp=00", bus.out0_data); end
    checks++; if (bus.out1_data !== 8'h00) begin failures++; $display("FAIL rst_d1 got=%h exp=00", bus.out1_data); end
    checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); end
    tick();
  endtask

  task automatic test_basic_steer();
    drive(1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
    tick();
    checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h3C) begin failures++; $display("FAIL steer0 got=%b/%h exp=1/3c", bus.out0_valid, bus.out0_data); end
    checks++; if (bus.out1_valid !== 1'b0) begin failures++; $display("FAIL steer0_other got=%b exp=0", bus.out1_valid); end
    drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    tick();
    checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'hA5) begin failures++; $display("FAIL steer1 got=%b/%h exp=1/a5", bus.out1_valid, bus.out1_data); end
    checks++; if (bus.out0_valid !== 1'b0) begin failures++; $display("FAIL steer1_other got=%b exp=0", bus.out0_valid); end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin failures++; $display("FAIL steer_cnt got=%0d/%0d exp=1/1", cnt0, cnt1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL steer_busy got=%b exp=0", busy); end
  endtask

  task automatic test_stall_isolation();
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h11) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/11", bus.out0_valid, bus.out0_data); end
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL free_lane_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'h33) begin failures++; $display("FAIL free_lane_out got=%b/%h exp=1/33", bus.out1_valid, bus.out1_data); end
    checks++; if (bus.out0_data !== 8'h11) begin failures++; $display("FAIL stall_hold2 got=%h exp=11", bus.out0_data); end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin failures++; $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", cnt0, cnt1, m_cnt0, m_cnt1); end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] start;
    start = m_cnt1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, W'(i), 1'b1, 1'b1);
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== W'(i)) begin failures++; $display("FAIL b2b_out[%0d] got=%b/%h exp=1/%h", i, bus.out1_valid, bus.out1_data, W'(i)); end
    end
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (cnt1 !== start + 8'd8) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", cnt1, start + 8'd8); end
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 1'b0, W'(i), 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (cnt0 !== 8'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", cnt0); end
    checks++; if (cnt1 !== 8'd0) begin failures++; $display("FAIL wrap_other got=%0d exp=0", cnt1); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
    tick();
    checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h5A) begin failures++; $display("FAIL mr_setup got=%b/%h exp=1/5a", bus.out0_valid, bus.out0_data); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out0_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", bus.out0_valid); end
    checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL mr_cnt got=%0d exp=0", cnt0); end
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mr_ready_busy got=%b/%b exp=0/0", bus.in_ready, busy); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mr_post_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h77) begin failures++; $display("FAIL mr_post_out got=%b/%h exp=1/77", bus.out0_valid, bus.out0_data); end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (cnt0 !== 8'd1) begin failures++; $display("FAIL mr_post_cnt got=%0d exp=1", cnt0); end
  endtask

  task automatic test_random();
    logic         pv, ps, acc;
    logic [W-1:0] pd;
    pv = 1'b0; ps = 1'b0; pd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        ps = 1'($urandom_range(0, 1));
        pd = W'($urandom_range(0, 255));
      end
      drive(pv, ps, pd, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      checks++; if (bus.in_ready !== m_rdy) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, bus.in_ready, m_rdy); end
      acc = pv && m_rdy;
      tick();
      if (acc) pv = 1'b0;
      checks++; if (bus.out0_valid !== (exp_q0.size() != 0)) begin failures++; $display("FAIL rnd_v0[%0d] got=%b exp=%b", n, bus.out0_valid, exp_q0.size() != 0); end
      checks++; if (bus.out1_valid !== (exp_q1.size() != 0)) begin failures++; $display("FAIL rnd_v1[%0d] got=%b exp=%b", n, bus.out1_valid, exp_q1.size() != 0); end
      if (exp_q0.size() != 0) begin
        checks++; if (bus.out0_data !== exp_q0[0]) begin failures++; $display("FAIL rnd_d0[%0d] got=%h exp=%h", n, bus.out0_data, exp_q0[0]); end
      end
      if (exp_q1.size() != 0) begin
        checks++; if (bus.out1_data !== exp_q1[0]) begin failures++; $display("FAIL rnd_d1[%0d] got=%h exp=%h", n, bus.out1_data, exp_q1[0]); end
      end
      checks++; if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n, cnt0, cnt1, m_cnt0, m_cnt1); end
      checks++; if (busy !== (exp_q0.size() != 0 || exp_q1.size() != 0)) begin failures++; $display("FAIL rnd_busy[%0d] got=%b", n, busy); end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    test_reset();
    test_basic_steer();
    test_stall_isolation();
    test_back_to_back();
    test_counter_wrap();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
